// File: rtl/seq1000_detector.sv
// Moore detector for the serial pattern 1,0,0,0 (oldest first); out is a registered state decode.
// Optional match counter enabled by defining SEQ1000_DETECTOR_COUNT_EN.
module seq1000_detector #(
    parameter int COUNT_W = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic out
`ifdef SEQ1000_DETECTOR_COUNT_EN
    ,
    output logic [COUNT_W-1:0] match_count
`endif
);

    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S100  = 3'd3,
        S1000 = 3'd4
    } state_t;

    state_t state_r;
    logic   out_r;
    state_t next_s;

    // Any 1 restarts the match from S1; unused encodings fall back to idle.
    function automatic state_t next_state_f(input state_t cur, input logic bit_v);
        state_t nxt;
        case (cur)
            S0:      nxt = bit_v ? S1 : S0;
            S1:      nxt = bit_v ? S1 : S10;
            S10:     nxt = bit_v ? S1 : S100;
            S100:    nxt = bit_v ? S1 : S1000;
            S1000:   nxt = bit_v ? S1 : S0;
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

    assign next_s = next_state_f(state_r, in);

    // State register with the detect flag registered alongside it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S0;
            out_r   <= 1'b0;
        end else begin
            state_r <= next_s;
            out_r   <= (next_s == S1000);
        end
    end

    assign out = out_r;

`ifdef SEQ1000_DETECTOR_COUNT_EN
    logic [COUNT_W-1:0] count_r;

    // Saturating count of entries into S1000.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if ((next_s == S1000) && (count_r != {COUNT_W{1'b1}})) begin
            count_r <= count_r + COUNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign match_count = count_r;
`endif

endmodule

// File: tb/tb_seq1000_detector.sv
// Self-checking bench for seq1000_detector: vector table plus hand-written reset/counter sequences.
module tb_seq1000_detector;

    localparam int COUNT_W = 2;

    logic clock;
    logic reset;
    logic in;
    logic out;
`ifdef SEQ1000_DETECTOR_COUNT_EN
    logic [COUNT_W-1:0] match_count;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic rst_v;
        logic in_v;
        logic exp_out;
    } vec_t;

    typedef struct {
        int   idx;
        logic exp_out;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[$];

    seq1000_detector #(.COUNT_W(COUNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .in          (in),
        .out         (out)
`ifdef SEQ1000_DETECTOR_COUNT_EN
        ,
        .match_count (match_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one bit at the falling edge, push expectation, compare 1 time unit after the rising edge.
    task automatic step(input int idx, input logic rst_v, input logic in_v, input logic exp_out);
        sb_t e;
        @(negedge clock);
        reset = rst_v;
        in    = in_v;
        sb_q.push_back('{idx, exp_out});
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        check($sformatf("vec%0d_out", e.idx), {31'd0, out}, {31'd0, e.exp_out});
    endtask

    task automatic add(input logic r, input logic i, input logic o);
        vecs.push_back('{r, i, o});
    endtask

    task automatic add_seq(input string bits, input string exps);
        for (int k = 0; k < bits.len(); k++)
            add(1'b1, bits[k] == "1", exps[k] == "1");
    endtask

    initial begin
        reset = 1'b0;
        in    = 1'b0;
        #2;
        check("reset_out", {31'd0, out}, 32'd0);

        // Reset held with in toggling, then released with in=0.
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0);
        add_seq("0010000",  "0000010");           // basic detect, drop after
        add_seq("1001000",  "0000001");           // partial broken, overlap on second 1
        add_seq("1000000",  "0001000");           // no retrigger on trailing zeros
        add_seq("10001000", "00010001");          // 1 right after detect restarts
        add_seq("110000",   "000010");            // repeated leading 1

        for (int i = 0; i < vecs.size(); i++)
            step(i, vecs[i].rst_v, vecs[i].in_v, vecs[i].exp_out);

        // Async reset while out is high must clear it without a clock edge.
        check("pre_async_out", {31'd0, out}, 32'd0);
        step(100, 1'b1, 1'b1, 1'b0);
        step(101, 1'b1, 1'b0, 1'b0);
        step(102, 1'b1, 1'b0, 1'b0);
        step(103, 1'b1, 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("async_clear_out", {31'd0, out}, 32'd0);
        #1;
        reset = 1'b1;

        // Async reset mid-sequence discards the partial 1,0,0.
        step(110, 1'b1, 1'b1, 1'b0);
        step(111, 1'b1, 1'b0, 1'b0);
        step(112, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        step(113, 1'b1, 1'b0, 1'b0);
        step(114, 1'b1, 1'b0, 1'b0);
        step(115, 1'b1, 1'b1, 1'b0);
        step(116, 1'b1, 1'b0, 1'b0);
        step(117, 1'b1, 1'b0, 1'b0);
        step(118, 1'b1, 1'b0, 1'b1);
        step(119, 1'b1, 1'b0, 1'b0);

`ifdef SEQ1000_DETECTOR_COUNT_EN
        // Counter: clear, then four detections saturate at 3.
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("cnt_reset", {30'd0, match_count}, 32'd0);
        reset = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step(200 + n * 4, 1'b1, 1'b1, 1'b0);
            step(201 + n * 4, 1'b1, 1'b0, 1'b0);
            step(202 + n * 4, 1'b1, 1'b0, 1'b0);
            step(203 + n * 4, 1'b1, 1'b0, 1'b1);
            check($sformatf("cnt_after_%0d", n + 1), {30'd0, match_count},
                  (n < 3) ? (n + 1) : 3);
        end
        #2;
        reset = 1'b0;
        #1;
        check("cnt_async_clear", {30'd0, match_count}, 32'd0);
        reset = 1'b1;
`endif

        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
